// File: rtl/cat_pkg.sv
// Shared types for the cat adoption scheduler: colour encoding, captured
// descriptor layout and scheduler FSM states.
package cat_pkg;

  typedef enum logic [1:0] {
    BLACK = 2'b10,
    WHITE = 2'b00,
    RED   = 2'b01,
    OTHER = 2'b11
  } colour_e;

  typedef struct packed {
    colour_e colour;
    logic    sterilized;
    logic    male;
  } cat_desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } sched_state_e;

  function automatic cat_desc_t make_desc(input logic is_black, input logic is_red,
                                          input logic is_sterilized, input logic is_male);
    cat_desc_t d;
    d.colour     = colour_e'({is_black, is_red});
    d.sterilized = is_sterilized;
    d.male       = is_male;
    return d;
  endfunction

endpackage

// File: rtl/cat_rule.sv
// Combinational acceptance rule on one captured descriptor; household
// capacity is deliberately not considered here.
module cat_rule
  import cat_pkg::*;
(
  input  cat_desc_t desc,
  output logic      accept
);

  logic is_black;
  logic is_white;
  logic is_red;

  assign is_black = (desc.colour == BLACK);
  assign is_white = (desc.colour == WHITE);
  assign is_red   = (desc.colour == RED);

  assign accept = is_black
                | (desc.sterilized &  desc.male & (is_white | is_red))
                | (desc.sterilized & ~desc.male & ~is_white);

endmodule

// File: rtl/cat_adoption_scheduler.sv
// Two-port round-robin intake, rule evaluation with capacity override and
// household occupancy tracking. Optional counters under CAT_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a descriptor handshake on the granted port
// EVAL  | registering the decision for the captured descriptor
// RESP  | result presented until the consumer takes it
module cat_adoption_scheduler
  import cat_pkg::*;
#(
  parameter int MAX_CATS = 4,
  parameter int CNT_W    = $clog2(MAX_CATS + 1)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [1:0]       ReqIsBlack,
  input  logic [1:0]       ReqIsRed,
  input  logic [1:0]       ReqIsSterilized,
  input  logic [1:0]       ReqIsMale,
  output logic             ResValid,
  input  logic             ResReady,
  output logic             ResAccept,
  output logic             ResSrc,
  input  logic             CatRelease,
  output logic [CNT_W-1:0] CatCount,
`ifdef CAT_STATS_EN
  output logic [15:0]      StatAccepts,
  output logic [15:0]      StatRejects,
`endif
  output logic             Full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CATS);

  sched_state_e     state_q, state_d;
  logic             ptr_q, ptr_d;
  cat_desc_t        desc_q, desc_d;
  logic             src_q, src_d;
  logic             accept_q, accept_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic grant;
  logic req_hs;
  logic res_hs;
  logic rule_accept;
  logic inc;
  logic dec;

  cat_rule u_rule (
    .desc   (desc_q),
    .accept (rule_accept)
  );

  // Pointer names the favoured port; fall back to the other one if it is idle.
  assign grant    = ReqValid[ptr_q] ? ptr_q : ~ptr_q;
  assign req_hs   = (state_q == IDLE) && (ReqValid != 2'b00);
  assign ReqReady = req_hs ? {grant, ~grant} : 2'b00;
  assign res_hs   = (state_q == RESP) && ResReady;

  assign inc = res_hs & accept_q & (count_q != MAX_CNT);
  assign dec = CatRelease & (count_q != '0);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    desc_d   = desc_q;
    src_d    = src_q;
    accept_d = accept_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          desc_d  = make_desc(ReqIsBlack[grant], ReqIsRed[grant],
                              ReqIsSterilized[grant], ReqIsMale[grant]);
          src_d   = grant;
          ptr_d   = ~grant;
          state_d = EVAL;
        end
      end
      EVAL: begin
        accept_d = rule_accept & ~full_q;
        state_d  = RESP;
      end
      RESP: begin
        if (ResReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    if (inc && !dec)      count_d = count_q + 1'b1;
    else if (dec && !inc) count_d = count_q - 1'b1;

    // Full deliberately lags the count by one cycle.
    full_d = (count_q == MAX_CNT);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      desc_q   <= '0;
      src_q    <= 1'b0;
      accept_q <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      desc_q   <= desc_d;
      src_q    <= src_d;
      accept_q <= accept_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign ResValid  = (state_q == RESP);
  assign ResAccept = accept_q;
  assign ResSrc    = src_q;
  assign CatCount  = count_q;
  assign Full      = full_q;

`ifdef CAT_STATS_EN
  logic [15:0] stat_acc_q, stat_acc_d;
  logic [15:0] stat_rej_q, stat_rej_d;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rej_d = stat_rej_q;
    if (res_hs) begin
      if (accept_q && stat_acc_q != 16'hFFFF)  stat_acc_d = stat_acc_q + 16'd1;
      if (!accept_q && stat_rej_q != 16'hFFFF) stat_rej_d = stat_rej_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stat_acc_q <= 16'd0;
      stat_rej_q <= 16'd0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rej_q <= stat_rej_d;
    end
  end

  assign StatAccepts = stat_acc_q;
  assign StatRejects = stat_rej_q;
`endif

endmodule

// File: tb/tb_cat_adoption_scheduler.sv
// Bench for cat_adoption_scheduler: directed scenarios then random traffic,
// compared every cycle against a transaction-level model. Honors CAT_STATS_EN.
module tb_cat_adoption_scheduler;

  localparam int MAX_CATS = 4;
  localparam int CNT_W    = $clog2(MAX_CATS + 1);

  logic             Clk = 1'b0;
  logic             RstN;
  logic [1:0]       ReqValid, ReqReady;
  logic [1:0]       ReqIsBlack, ReqIsRed, ReqIsSterilized, ReqIsMale;
  logic             ResValid, ResReady, ResAccept, ResSrc;
  logic             CatRelease;
  logic [CNT_W-1:0] CatCount;
  logic             Full;
`ifdef CAT_STATS_EN
  logic [15:0]      StatAccepts, StatRejects;
`endif

  cat_adoption_scheduler #(.MAX_CATS(MAX_CATS)) dut (
    .Clk             (Clk),
    .RstN            (RstN),
    .ReqValid        (ReqValid),
    .ReqReady        (ReqReady),
    .ReqIsBlack      (ReqIsBlack),
    .ReqIsRed        (ReqIsRed),
    .ReqIsSterilized (ReqIsSterilized),
    .ReqIsMale       (ReqIsMale),
    .ResValid        (ResValid),
    .ResReady        (ResReady),
    .ResAccept       (ResAccept),
    .ResSrc          (ResSrc),
    .CatRelease      (CatRelease),
    .CatCount        (CatCount),
`ifdef CAT_STATS_EN
    .StatAccepts     (StatAccepts),
    .StatRejects     (StatRejects),
`endif
    .Full            (Full)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one outstanding transaction, age 1 = deciding, age 2 = presenting.
  int m_busy, m_age, m_last, m_src, m_acc, m_count, m_full;
  int m_b, m_r, m_s, m_m;
  int m_sacc, m_srej;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_accept(input int b, input int r, input int s, input int m);
    if (b == 1 && r == 0) return 1;
    if (s == 0) return 0;
    if (m == 1) return (b == 0) ? 1 : 0;
    return (b == 1 || r == 1) ? 1 : 0;
  endfunction

  function automatic int model_pick();
    int fav;
    if (m_busy != 0) return -1;
    fav = 1 - m_last;
    if (ReqValid[fav]) return fav;
    if (ReqValid[1 - fav]) return 1 - fav;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = 1; m_src = 0; m_acc = 0;
    m_count = 0; m_full = 0; m_sacc = 0; m_srej = 0;
    m_b = 0; m_r = 0; m_s = 0; m_m = 0;
  endtask

  task automatic model_step();
    int pick, cnt0, res_take, inc, dec;
    pick     = model_pick();
    cnt0     = m_count;
    res_take = (m_busy != 0 && m_age == 2 && ResReady) ? 1 : 0;
    inc      = (res_take != 0 && m_acc != 0) ? 1 : 0;
    dec      = (CatRelease && cnt0 > 0) ? 1 : 0;
    if (res_take != 0) begin
      if (m_acc != 0) begin if (m_sacc < 65535) m_sacc++; end
      else begin if (m_srej < 65535) m_srej++; end
    end
    if (pick >= 0) begin
      m_busy = 1; m_age = 1; m_src = pick; m_last = pick;
      m_b = ReqIsBlack[pick]; m_r = ReqIsRed[pick];
      m_s = ReqIsSterilized[pick]; m_m = ReqIsMale[pick];
    end else if (m_busy != 0 && m_age == 1) begin
      m_acc = (model_accept(m_b, m_r, m_s, m_m) != 0 && m_full == 0) ? 1 : 0;
      m_age = 2;
    end else if (res_take != 0) begin
      m_busy = 0; m_age = 0;
    end
    m_count = cnt0 + inc - dec;
    if (m_count > MAX_CATS) m_count = MAX_CATS;
    m_full = (cnt0 == MAX_CATS) ? 1 : 0;
  endtask

  task automatic check_all();
    int pick;
    pick = model_pick();
    check_val("req_ready", 32'(ReqReady), (pick < 0) ? 32'd0 : (32'd1 << pick));
    check_val("res_valid", 32'(ResValid), (m_busy != 0 && m_age == 2) ? 32'd1 : 32'd0);
    check_val("res_accept", 32'(ResAccept), 32'(m_acc));
    check_val("res_src", 32'(ResSrc), 32'(m_src));
    check_val("cat_count", 32'(CatCount), 32'(m_count));
    check_val("full", 32'(Full), 32'(m_full));
`ifdef CAT_STATS_EN
    check_val("stat_accepts", 32'(StatAccepts), 32'(m_sacc));
    check_val("stat_rejects", 32'(StatRejects), 32'(m_srej));
`endif
  endtask

  task automatic tick();
    #1;
    check_all();
    if (RstN) model_step();
    else model_reset();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic offer(input logic [1:0] v, input logic b, input logic r,
                       input logic s, input logic m);
    ReqValid        = v;
    ReqIsBlack      = {b, b};
    ReqIsRed        = {r, r};
    ReqIsSterilized = {s, s};
    ReqIsMale       = {m, m};
  endtask

  task automatic idle(input int n);
    ReqValid = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RstN = 1'b0;
    offer(2'b00, 0, 0, 0, 0);
    ResReady   = 1'b1;
    CatRelease = 1'b0;
    model_reset();
    @(negedge Clk);
    tick();
    tick();
    RstN = 1'b1;
    tick();

    // white unsterilized male on port 0: rejected, count unchanged
    offer(2'b01, 0, 0, 0, 1);
    tick();
    idle(4);

    // both ports streaming black cats fill the household
    offer(2'b11, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick();
    idle(2);
    check_val("filled_count", 32'(CatCount), 32'd4);
    check_val("filled_full", 32'(Full), 32'd1);

    // sterilized red female rejected while full, accepted after a release
    offer(2'b01, 0, 1, 1, 0);
    tick();
    idle(3);
    CatRelease = 1'b1;
    tick();
    CatRelease = 1'b0;
    idle(2);
    offer(2'b01, 0, 1, 1, 0);
    tick();
    idle(3);
    check_val("refill_count", 32'(CatCount), 32'd4);

    // consumer stalls in RESP with both ports still requesting
    CatRelease = 1'b1;
    tick();
    CatRelease = 1'b0;
    idle(1);
    offer(2'b10, 1, 0, 0, 0);
    tick();
    ResReady = 1'b0;
    offer(2'b11, 1, 1, 1, 1);
    for (int i = 0; i < 7; i++) tick();
    ReqValid = 2'b00;
    ResReady = 1'b1;
    idle(3);

    // release coincident with an accepting result at count 2
    CatRelease = 1'b1;
    idle(2);
    CatRelease = 1'b0;
    idle(1);
    check_val("pre_coincide", 32'(CatCount), 32'd2);
    offer(2'b01, 1, 0, 0, 0);
    tick();
    ReqValid = 2'b00;
    tick();
    CatRelease = 1'b1;
    tick();
    CatRelease = 1'b0;
    idle(1);
    check_val("coincide_count", 32'(CatCount), 32'd2);
    CatRelease = 1'b1;
    idle(4);
    CatRelease = 1'b0;
    idle(1);
    check_val("floor_count", 32'(CatCount), 32'd0);

    // reset during EVAL drops the transaction
    offer(2'b10, 1, 0, 0, 0);
    tick();
    ReqValid = 2'b00;
    RstN = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    RstN = 1'b1;
    idle(3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      ReqValid        = 2'($urandom_range(0, 3));
      ReqIsBlack      = 2'($urandom_range(0, 3));
      ReqIsRed        = 2'($urandom_range(0, 3));
      ReqIsSterilized = 2'($urandom_range(0, 3));
      ReqIsMale       = 2'($urandom_range(0, 3));
      ResReady        = ($urandom_range(0, 3) != 0);
      CatRelease      = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cat_adoption_scheduler.md
# cat_adoption_scheduler

Sequencing and arbitration controller for the household cat-acceptance decision. Two intake requesters (shelter ports 0 and 1) offer cat descriptors over valid/ready handshakes. The block arbitrates round-robin between them, evaluates the acceptance rule on the captured descriptor, and returns a registered accept/reject result. It also tracks household occupancy against a configurable capacity and sits between the intake interfaces and the household bookkeeping logic.

## Interface
- MAX_CATS, default 4: household capacity; legal range 1..255.
- CNT_W, default $clog2(MAX_CATS+1): occupancy counter width (derived, not overridden).
- Clk  in  1  clock, rising edge.
- RstN  in  1  asynchronous, active-low reset.
- ReqValid  in  2  per-requester descriptor valid.
- ReqReady  out  2  per-requester ready; at most one bit high.
- ReqIsBlack  in  2  per-requester colour bit B.
- ReqIsRed  in  2  per-requester colour bit R.
- ReqIsSterilized  in  2  per-requester sterilized flag.
- ReqIsMale  in  2  per-requester sex flag.
- ResValid  out  1  result valid.
- ResReady  in  1  result consumer ready.
- ResAccept  out  1  1 = cat accepted.
- ResSrc  out  1  requester index of the result.
- CatRelease  in  1  one-cycle pulse: one resident cat leaves.
- CatCount  out  CNT_W  current occupancy.
- Full  out  1  CatCount == MAX_CATS.

## Operation
- Colour from {B,R}: 10 black, 00 white, 01 red, 11 other.
- Rule: accept when (a) black; or (b) sterilized male and colour white or red; or (c) sterilized female and colour not white.
- Capacity override: if Full at the EVAL cycle, the decision is reject regardless of the rule.
- FSM states: IDLE, EVAL, RESP.
  - IDLE: ReqReady is driven to the granted requester only when its ReqValid is high. A handshake captures the descriptor and ResSrc, then moves to EVAL.
  - EVAL: the decision is registered into ResAccept, then moves to RESP.
  - RESP: ResValid is high. ResAccept and ResSrc are held stable until ResValid && ResReady, then the FSM returns to IDLE.
- Arbitration: round-robin. The priority pointer points at the requester not served last and updates on each request handshake. After reset the pointer favours requester 0. A lone valid requester is always granted.
- ReqReady is combinational from state, pointer and ReqValid. It is 0 outside IDLE.
- Occupancy:
  - +1 on a result handshake with ResAccept=1.
  - -1 on CatRelease when CatCount > 0. CatRelease at 0 is ignored.
  - Simultaneous increment and release: net unchanged.
  - Count never exceeds MAX_CATS.

## Timing
- Reset values: ReqReady=0, ResValid=0, ResAccept=0, ResSrc=0, CatCount=0, Full=0. FSM=IDLE, pointer=0.
- Latency: handshake in cycle N gives EVAL in cycle N+1 and ResValid high from cycle N+2.
- Throughput: one descriptor per 3 cycles when ResReady is held high.
- Full is a registered function of CatCount. It updates the cycle after the count changes.
- Full is sampled in EVAL. A release that lands during EVAL therefore does not rescue that request.
- Reset asserted mid-transaction aborts it: the result is lost, no count change occurs, and the FSM returns to IDLE.
- Changes to ReqValid or data while ReqReady is low have no effect.

## Configuration
- CAT_STATS_EN:
  - Defined: adds outputs StatAccepts and StatRejects, 16 bits each, reset 0.
  - Each increments on the result handshake according to ResAccept, saturating at 16'hFFFF.
  - Capacity-forced rejects count as rejects.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package cat_pkg contains:
  - colour_e enum: BLACK, WHITE, RED, OTHER.
  - cat_desc_t struct: colour, sterilized, male.
  - sched_state_e enum: IDLE, EVAL, RESP.
- Sub-module cat_rule: purely combinational. Maps cat_desc_t to accept, using the rule above without the capacity override.
- Capacity override, arbiter, FSM and counters live in cat_adoption_scheduler.

## Test plan
- Reset, then a single white, unsterilized male on port 0 → ReqReady[0] high that cycle; ResValid 2 cycles later with ResAccept=0, ResSrc=0; CatCount stays 0.
- Both ports continuously valid with black cats, ResReady=1 → grants alternate 0,1,0,1; four accepts; CatCount=4, Full=1.
- Full with MAX_CATS=4, then a sterilized red female offered → ResAccept=0. CatRelease pulse → CatCount=3, Full=0. Next identical offer → ResAccept=1.
- ResReady held low for 5 cycles in RESP → ResValid, ResAccept and ResSrc stable, ReqReady=0 throughout. Release ResReady → single count update.
- CatRelease in the same cycle as an accepting result handshake at CatCount=2 → CatCount stays 2. CatRelease at CatCount=0 → stays 0.
- RstN pulsed low during EVAL → all outputs return to reset values immediately; no result emitted. With CAT_STATS_EN, StatAccepts and StatRejects also read 0.
